// File: rtl/lut_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational LUT.
// A granted access takes two cycles. In the grant cycle (state READ) the
// address register drives the LUT. In the following cycle the registered
// data and the owner's valid pulse appear.
module lut_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state, state_nxt;
  logic                ptr, ptr_nxt;      // requester favoured on a tie
  logic                owner, owner_nxt;  // requester whose access is in flight
  logic                win;
  logic [ADDR_W-1:0]   lut_addr_nxt;
  logic [DATA_W-1:0]   rd_data_nxt;
  logic [1:0]          gnt_nxt, rdv_nxt;

  // Next-state logic. Requests are looked at only in IDLE, so a request
  // still held during the grant cycle cannot start a second access.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    lut_addr_nxt = lut_addr;
    rd_data_nxt  = rd_data;
    gnt_nxt      = 2'b00;
    rdv_nxt      = 2'b00;
    win          = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // A lone requester wins outright. On a tie the pointer decides.
          win          = (req0 && req1) ? ptr : req1;
          state_nxt    = READ;
          owner_nxt    = win;
          ptr_nxt      = ~win;
          lut_addr_nxt = win ? addr1 : addr0;
          gnt_nxt      = win ? 2'b10 : 2'b01;
        end
      end
      READ: begin
        rd_data_nxt = lut_data;
        rdv_nxt     = owner ? 2'b10 : 2'b01;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers. Reset also cancels an access that is in
  // flight: no valid pulse is produced and the data register is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      lut_addr  <= '0;
      rd_data   <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rd_valid0 <= 1'b0;
      rd_valid1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      lut_addr  <= lut_addr_nxt;
      rd_data   <= rd_data_nxt;
      gnt0      <= gnt_nxt[0];
      gnt1      <= gnt_nxt[1];
      rd_valid0 <= rdv_nxt[0];
      rd_valid1 <= rdv_nxt[1];
    end
  end

  assign busy = (state == READ);

endmodule

// File: tb/tb_lut_arbiter.sv
// Scoreboard bench for lut_arbiter. The stimulus queues the grant and
// read-data events it expects. A negedge monitor pops an entry and compares
// it each time the DUT pulses a grant or a read-valid.
module tb_lut_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic              gnt0, gnt1, rd_valid0, rd_valid1, busy;
  logic [DATA_W-1:0] rd_data;

  int compared = 0;
  int mismatched = 0;
  logic hold0 = 1'b0, hold1 = 1'b0;

  typedef struct {
    logic       is_rd;   // 0: grant (value = lut_addr), 1: read (value = rd_data)
    logic       who;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  lut_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .gnt0(gnt0), .gnt1(gnt1), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // LUT contents: entry k = 60+k for k 0..16, entry 31 = 32
  function automatic logic [7:0] mem_lut(input logic [4:0] k);
    if (k <= 5'd16) return 8'd60 + {3'b000, k};
    if (k == 5'd31) return 8'd32;
    return 8'hEE;
  endfunction
  assign lut_data = mem_lut(lut_addr);

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic is_rd, input logic who, input logic [7:0] val);
    exp_t e;
    e.is_rd = is_rd; e.who = who; e.val = val;
    exp_q.push_back(e);
  endtask

  // Requester model: drop the request once granted unless told to hold it
  task automatic tick();
    @(posedge clk); #1;
    if (gnt0 && !hold0) req0 = 1'b0;
    if (gnt1 && !hold1) req1 = 1'b0;
  endtask

  task automatic drain(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: %0d expected events never arrived", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: checks pulse exclusivity, busy, and pops the scoreboard
  always @(negedge clk) begin
    exp_t e;
    compared++;
    if ((gnt0 && gnt1) || (rd_valid0 && rd_valid1)) begin
      mismatched++;
      $display("FAIL excl: gnt=%b%b rd_valid=%b%b, at most one of each allowed",
               gnt1, gnt0, rd_valid1, rd_valid0);
    end
    compared++;
    if (busy !== (gnt0 | gnt1)) begin
      mismatched++;
      $display("FAIL busy: got %b expected %b", busy, gnt0 | gnt1);
    end
    if (gnt0 || gnt1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL grant: unexpected gnt=%b%b addr=%0d", gnt1, gnt0, lut_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_rd || e.who != gnt1 || {3'b000, lut_addr} != e.val) begin
          mismatched++;
          $display("FAIL grant: got gnt%0d addr=%0d expected %s%0d val=%0d",
                   gnt1, lut_addr, e.is_rd ? "rd_valid" : "gnt", e.who, e.val);
        end
      end
    end
    if (rd_valid0 || rd_valid1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL read: unexpected rd_valid=%b%b data=%0d", rd_valid1, rd_valid0, rd_data);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_rd || e.who != rd_valid1 || rd_data != e.val) begin
          mismatched++;
          $display("FAIL read: got rd_valid%0d data=%0d expected %s%0d val=%0d",
                   rd_valid1, rd_data, e.is_rd ? "rd_valid" : "gnt", e.who, e.val);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {gnt0, gnt1, rd_valid0, rd_valid1}, 0);

    // V1: single access from requester 0
    push(0, 0, 8'd3); push(1, 0, 8'd63);
    req0 = 1'b1; addr0 = 5'd3;
    tick();
    chk("v1_busy_gnt", busy, 1);
    chk("v1_lut_addr", lut_addr, 3);
    tick();
    chk("v1_busy_rd", busy, 0);
    chk("v1_rd_data", rd_data, 63);
    tick();

    // V6: idle with no requests leaves the address and data registers alone
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("v6_lut_addr", lut_addr, 3);
      chk("v6_rd_data", rd_data, 63);
    end

    // V2: tie right after reset, so requester 0 goes first
    reset = 1'b1; tick(); reset = 1'b0;
    push(0, 0, 8'd1);  push(1, 0, 8'd61);
    push(0, 1, 8'd31); push(1, 1, 8'd32);
    req0 = 1'b1; addr0 = 5'd1; req1 = 1'b1; addr1 = 5'd31;
    drain(20, "v2_drain");

    // V3: both held for 8 accesses, so grants alternate starting with 0
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 8'd5);  push(1, 0, 8'd65);
      push(0, 1, 8'd16); push(1, 1, 8'd76);
    end
    hold0 = 1'b1; hold1 = 1'b1;
    req0 = 1'b1; addr0 = 5'd5; req1 = 1'b1; addr1 = 5'd16;
    repeat (16) tick();
    req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    drain(6, "v3_drain");

    // V4: req1 held through its grant cycle produces exactly one access
    push(0, 1, 8'd16); push(1, 1, 8'd76);
    hold1 = 1'b1; req1 = 1'b1; addr1 = 5'd16;
    tick();
    tick();
    req1 = 1'b0; hold1 = 1'b0;
    chk("v4_rd_data", rd_data, 76);
    repeat (4) tick();
    drain(2, "v4_drain");

    // V5: reset during the READ cycle cancels the access
    push(0, 0, 8'd7);
    req0 = 1'b1; addr0 = 5'd7;
    tick();
    chk("v5_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("v5_busy", busy, 0);
    chk("v5_rd_data", rd_data, 0);
    chk("v5_rd_valid", {rd_valid0, rd_valid1}, 0);
    chk("v5_lut_addr", lut_addr, 0);
    // The pointer is back at 0, so a tie goes to requester 0
    push(0, 0, 8'd2); push(1, 0, 8'd62);
    push(0, 1, 8'd9); push(1, 1, 8'd69);
    req0 = 1'b1; addr0 = 5'd2; req1 = 1'b1; addr1 = 5'd9;
    drain(20, "v5_tie_drain");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lut_arbiter.md
LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 5, LUT address width.
- REQ-002 Parameter DATA_W, default 8, LUT data width.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 req0  input  1  requester 0 read request; held high with addr0 stable until gnt0.
- REQ-006 addr0  input  ADDR_W  requester 0 table address.
- REQ-007 req1  input  1  requester 1 read request; same rule as req0.
- REQ-008 addr1  input  ADDR_W  requester 1 table address.
- REQ-009 lut_addr  output  ADDR_W  registered address driven to the shared combinational LUT.
- REQ-010 lut_data  input  DATA_W  combinational LUT read data for lut_addr.
- REQ-011 gnt0, gnt1  output  1 each  one-cycle grant pulses.
- REQ-012 rd_valid0, rd_valid1  output  1 each  one-cycle read-data-valid pulses.
- REQ-013 rd_data  output  DATA_W  registered read data, shared by both requesters.
- REQ-014 busy  output  1  high while an access is in flight (state READ).

Function
- REQ-015 FSM states SHALL be IDLE and READ only; reset state IDLE.
- REQ-016 In IDLE with no request at edge T: stay IDLE; lut_addr and rd_data hold; gnt*/rd_valid* low.
- REQ-017 In IDLE with winner W at edge T: at T+1 lut_addr=addrW, gntW=1 for exactly one cycle, owner=W, state READ, busy=1.
- REQ-018 In READ at edge T+2: rd_data=lut_data, rd_validW=1 for exactly one cycle, state IDLE, busy=0.
- REQ-019 Latency: request sampled at T -> grant at T+1 -> data at T+2; max throughput one access per 2 cycles.
- REQ-020 Requests SHALL NOT be sampled in READ; a req held through the grant cycle SHALL NOT cause a duplicate access.
- REQ-021 Arbitration: round-robin priority pointer ptr, reset value 0 (requester 0 favoured).
- REQ-022 Only one requester active: that requester wins regardless of ptr.
- REQ-023 Both active: requester indexed by ptr wins.
- REQ-024 After every grant ptr SHALL point to the non-winning requester.
- REQ-025 At most one of gnt0/gnt1 high per cycle; at most one of rd_valid0/rd_valid1 high per cycle.
- REQ-026 rd_data holds its last captured value until the next capture.
- REQ-027 All addresses 0..2^ADDR_W-1 SHALL be passed through unchanged; no range checking; lut_data returned as-is.
- REQ-028 A requester deasserting req before its grant SHALL be treated as withdrawn; no access issued for it.

Reset
- REQ-029 On reset: state IDLE, ptr 0, owner 0, lut_addr 0, rd_data 0, gnt0/gnt1/rd_valid0/rd_valid1/busy 0.
- REQ-030 Reset asserted in READ SHALL abort the access: no rd_valid pulse, rd_data forced to 0.
- REQ-031 Reset SHALL take priority over all simultaneous requests.

Verification
Bench drives lut_data from the team's mem_LUT table (entry k = 60+k for k 0..16, entry 31 = 32).
- V1 Single: req0=1, addr0=3 at T -> gnt0 at T+1, lut_addr=3; rd_valid0, rd_data=63 at T+2; busy high only at T+1.
- V2 Tie after reset: req0 (addr 1) and req1 (addr 31) held -> requester 0 granted first (rd_data=61), then requester 1 (rd_data=32); grants 2 cycles apart.
- V3 Fairness: both held continuously for 8 accesses -> grants alternate 0,1,0,1,...; no back-to-back grants to one requester.
- V4 Hold-through-grant: req1=1, addr1=16 held one cycle past gnt1 -> exactly one rd_valid1, rd_data=76; no second grant.
- V5 Reset mid-access: reset high in the READ cycle -> no rd_valid, rd_data=0, busy=0, ptr=0 on the next cycle.
- V6 Idle hold: after V1 drop all requests for 5 cycles -> lut_addr=3 and rd_data=63 stable; no pulses on gnt or rd_valid.
